// File: rtl/threefish_pkg.sv
// Shared constants, types and key-schedule helpers for the Threefish-512 decrypt core.
// Words are 64 bits; a block is eight words packed with word 0 in the low bits.
package threefish_pkg;

    localparam int WORD_W      = 64;
    localparam int NUM_WORDS   = 8;
    localparam int KEY_WORDS   = 9;
    localparam int TWEAK_WORDS = 3;
    localparam int BLOCK_W     = WORD_W * NUM_WORDS;
    localparam int TWEAK_W     = 2 * WORD_W;
    localparam int NUM_ROUNDS  = 72;
    localparam int RND_W       = $clog2(NUM_ROUNDS);
    localparam int SUBKEY_W    = $clog2(NUM_ROUNDS / 4 + 1);

    localparam logic [WORD_W-1:0] C240 = 64'h1BD11BDAA9FC1A22;

    typedef logic [WORD_W-1:0]          word_t;
    typedef word_t [NUM_WORDS-1:0]      block_t;
    typedef word_t [KEY_WORDS-1:0]      key_t;
    typedef word_t [TWEAK_WORDS-1:0]    tweak_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Rotation constants indexed by [round mod 8][mix pair].
    localparam int ROT [8][4] = '{
        '{46, 36, 19, 37},
        '{33, 27, 14, 42},
        '{17, 49, 36, 39},
        '{44,  9, 54, 56},
        '{39, 30, 34, 24},
        '{13, 50, 10, 17},
        '{25, 29, 39, 43},
        '{ 8, 35, 56, 22}
    };

    localparam int PI     [8] = '{2, 1, 4, 7, 6, 5, 0, 3};
    localparam int INV_PI [8] = '{6, 1, 0, 7, 2, 5, 4, 3};

    function automatic word_t subkey_word(input key_t k, input tweak_t t,
                                          input logic [SUBKEY_W-1:0] s, input int i);
        word_t w;
        int    si;
        si = int'(s);
        w  = k[4'((si + i) % KEY_WORDS)];
        case (i)
            5:       w = w + t[2'(si % TWEAK_WORDS)];
            6:       w = w + t[2'((si + 1) % TWEAK_WORDS)];
            7:       w = w + WORD_W'(s);
            default: w = w;
        endcase
        return w;
    endfunction

    function automatic word_t rotr64(input word_t x, input logic [5:0] r);
        return (x >> r) | (x << (6'd0 - r));
    endfunction

endpackage

// File: rtl/threefish_decrypt_core_inv_round_func.sv
// One combinational Threefish-512 inverse round: undo the word permutation,
// undo the four MIX operations, then remove the subkey on every fourth round.
module inv_round_func
    import threefish_pkg::*;
(
    input  block_t           block_i,
    input  block_t           subkey_i,
    input  logic [RND_W-1:0] round_i,
    output block_t           block_o
);

    block_t perm;
    block_t mixed;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WORDS; gi++) begin : g_perm
            assign perm[gi] = block_i[INV_PI[gi]];
        end

        for (gi = 0; gi < NUM_WORDS / 2; gi++) begin : g_mix
            logic [5:0] rot;
            word_t      b_new;
            assign rot   = 6'(ROT[round_i[2:0]][gi]);
            assign b_new = rotr64(perm[2*gi+1] ^ perm[2*gi], rot);
            assign mixed[2*gi+1] = b_new;
            assign mixed[2*gi]   = perm[2*gi] - b_new;
        end

        for (gi = 0; gi < NUM_WORDS; gi++) begin : g_key
            assign block_o[gi] = (round_i[1:0] == 2'd0) ? mixed[gi] - subkey_i[gi]
                                                         : mixed[gi];
        end
    endgenerate

endmodule

// File: rtl/threefish_decrypt_core.sv
// Iterative Threefish-512 decryption: one inverse round per clock, subkeys
// derived on the fly from the registered key and tweak words.
module threefish_decrypt_core
    import threefish_pkg::*;
(
    input  logic               inClk,
    input  logic               inReset,
    input  logic               inValid,
    output logic               outInReady,
    input  logic [BLOCK_W-1:0] inKey,
    input  logic [TWEAK_W-1:0] inTweak,
    input  logic [BLOCK_W-1:0] inBlock,
    output logic               outValid,
    input  logic               inOutReady,
    output logic [BLOCK_W-1:0] outBlock
);

    state_t              state_q, state_d;
    logic [RND_W-1:0]    rnd_q, rnd_d;
    key_t                k_q, k_d;
    tweak_t              t_q, t_d;
    block_t              block_q, block_d;
    block_t              out_block_q, out_block_d;
    logic                out_valid_q, out_valid_d;

    word_t               key_par;
    logic [SUBKEY_W-1:0] subkey_s;
    block_t              subkey;
    block_t              load_block;
    block_t              rf_block;

    always_comb begin
        key_par = C240;
        for (int i = 0; i < NUM_WORDS; i++) begin
            key_par = key_par ^ inKey[WORD_W*i +: WORD_W];
        end
    end

    // LOAD strips the last subkey; each ROUND uses subkey d/4.
    assign subkey_s = (state_q == LOAD) ? SUBKEY_W'(NUM_ROUNDS / 4) : rnd_q[RND_W-1:2];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WORDS; gi++) begin : g_subkey
            assign subkey[gi]     = subkey_word(k_q, t_q, subkey_s, gi);
            assign load_block[gi] = block_q[gi] - subkey[gi];
        end
    endgenerate

    inv_round_func u_inv_round (
        .block_i  (block_q),
        .subkey_i (subkey),
        .round_i  (rnd_q),
        .block_o  (rf_block)
    );

    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        k_d         = k_q;
        t_d         = t_q;
        block_d     = block_q;
        out_block_d = out_block_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (inValid) begin
                    k_d     = {key_par, inKey};
                    t_d     = {inTweak[TWEAK_W-1:WORD_W] ^ inTweak[WORD_W-1:0], inTweak};
                    block_d = inBlock;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                block_d = load_block;
                rnd_d   = RND_W'(NUM_ROUNDS - 1);
                state_d = ROUND;
            end
            ROUND: begin
                block_d = rf_block;
                if (rnd_q == '0) begin
                    out_block_d = rf_block;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    rnd_d = rnd_q - RND_W'(1);
                end
            end
            DONE: begin
                if (inOutReady) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge inClk) begin
        if (inReset) begin
            state_q     <= IDLE;
            rnd_q       <= RND_W'(NUM_ROUNDS - 1);
            k_q         <= '0;
            t_q         <= '0;
            block_q     <= '0;
            out_block_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            k_q         <= k_d;
            t_q         <= t_d;
            block_q     <= block_d;
            out_block_q <= out_block_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign outInReady = (state_q == IDLE);
    assign outValid   = out_valid_q;
    assign outBlock   = out_block_q;

endmodule

// File: tb/tb_threefish_decrypt_core.sv
// Scoreboarded bench: plaintexts are encrypted by a forward Threefish-512 model,
// the ciphertext is fed to the decrypt core and the recovered plaintext is checked.
module tb_threefish_decrypt_core;

    logic         inClk = 1'b0;
    logic         inReset = 1'b1;
    logic         inValid = 1'b0;
    logic         outInReady;
    logic [511:0] inKey = '0;
    logic [127:0] inTweak = '0;
    logic [511:0] inBlock = '0;
    logic         outValid;
    logic         inOutReady = 1'b1;
    logic [511:0] outBlock;

    threefish_decrypt_core dut (
        .inClk      (inClk),
        .inReset    (inReset),
        .inValid    (inValid),
        .outInReady (outInReady),
        .inKey      (inKey),
        .inTweak    (inTweak),
        .inBlock    (inBlock),
        .outValid   (outValid),
        .inOutReady (inOutReady),
        .outBlock   (outBlock)
    );

    always #5 inClk = ~inClk;

    int cyc = 0;
    always @(posedge inClk) cyc <= cyc + 1;

    localparam logic [63:0] K_C240 = 64'h1BD11BDAA9FC1A22;
    localparam int ROTT [8][4] = '{
        '{46, 36, 19, 37}, '{33, 27, 14, 42}, '{17, 49, 36, 39}, '{44, 9, 54, 56},
        '{39, 30, 34, 24}, '{13, 50, 10, 17}, '{25, 29, 39, 43}, '{8, 35, 56, 22}
    };
    localparam int PERM [8] = '{2, 1, 4, 7, 6, 5, 0, 3};

    int n_checks = 0;
    int n_fail   = 0;
    logic [511:0] exp_q[$];
    int           acc_q[$];
    int           last_hs = 0;
    logic         prev_valid = 1'b0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Forward Threefish-512 encryption straight from the cipher definition.
    function automatic logic [511:0] tf_encrypt(input logic [511:0] key, input logic [127:0] tw,
                                                input logic [511:0] pt);
        logic [63:0]  k [9];
        logic [63:0]  t [3];
        logic [63:0]  v [8];
        logic [63:0]  f [8];
        logic [63:0]  w;
        logic [511:0] ct;
        int           s;
        int           r;
        k[8] = K_C240;
        for (int i = 0; i < 8; i++) begin
            k[i] = key[64*i +: 64];
            k[8] = k[8] ^ k[i];
            v[i] = pt[64*i +: 64];
        end
        t[0] = tw[63:0];
        t[1] = tw[127:64];
        t[2] = t[0] ^ t[1];
        for (int d = 0; d <= 72; d++) begin
            if (d % 4 == 0) begin
                s = d / 4;
                for (int i = 0; i < 8; i++) begin
                    w = k[(s + i) % 9];
                    if (i == 5) w = w + t[s % 3];
                    if (i == 6) w = w + t[(s + 1) % 3];
                    if (i == 7) w = w + 64'(s);
                    v[i] = v[i] + w;
                end
            end
            if (d == 72) break;
            for (int j = 0; j < 4; j++) begin
                r = ROTT[d % 8][j];
                v[2*j]   = v[2*j] + v[2*j+1];
                v[2*j+1] = ((v[2*j+1] << r) | (v[2*j+1] >> (64 - r))) ^ v[2*j];
            end
            for (int i = 0; i < 8; i++) f[i] = v[PERM[i]];
            for (int i = 0; i < 8; i++) v[i] = f[i];
        end
        for (int i = 0; i < 8; i++) ct[64*i +: 64] = v[i];
        return ct;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Monitor: latency of each completion and plaintext at each output handshake.
    always @(negedge inClk) begin
        int a;
        if (inReset) begin
            prev_valid = 1'b0;
        end else begin
            if (inValid && outInReady) acc_q.push_back(cyc + 1);
            if (outValid && !prev_valid) begin
                if (acc_q.size() == 0) begin
                    check("valid_without_accept", 512'd1, 512'd0);
                end else begin
                    a = acc_q.pop_front();
                    check("latency", 512'(cyc - a), 512'd73);
                end
            end
            if (outValid && inOutReady) begin
                last_hs = cyc + 1;
                if (exp_q.size() == 0) check("unexpected_output", 512'd1, 512'd0);
                else check("plaintext", outBlock, exp_q.pop_front());
            end
            prev_valid = outValid;
        end
    end

    // All driver tasks start and end just after a rising edge.
    task automatic send(input logic [511:0] key, input logic [127:0] tw, input logic [511:0] ct,
                        input bit keep, output int acc_cyc);
        bit got;
        got     = 1'b0;
        inKey   = key;
        inTweak = tw;
        inBlock = ct;
        inValid = 1'b1;
        for (int w = 0; w < 300 && !got; w++) begin
            @(negedge inClk);
            got = outInReady;
            @(posedge inClk);
            #1;
        end
        acc_cyc = cyc;
        if (!got) check("accept_timeout", 512'd0, 512'd1);
        if (!keep) inValid = 1'b0;
    endtask

    task automatic expect_and_send(input logic [511:0] key, input logic [127:0] tw,
                                   input logic [511:0] pt, input bit keep, output int acc_cyc);
        exp_q.push_back(pt);
        send(key, tw, tf_encrypt(key, tw, pt), keep, acc_cyc);
    endtask

    task automatic drain();
        for (int w = 0; w < 400 && exp_q.size() != 0; w++) begin
            @(posedge inClk);
            #1;
        end
        check("drain_timeout", 512'(exp_q.size()), 512'd0);
    endtask

    task automatic pulse_reset();
        inReset = 1'b1;
        inValid = 1'b0;
        exp_q.delete();
        acc_q.delete();
        @(posedge inClk);
        #1;
        inReset = 1'b0;
    endtask

    initial begin
        logic [511:0] key, pt, bp_pt;
        logic [127:0] tw;
        int           a1, a2;
        bit           seen;

        repeat (3) @(posedge inClk);
        #1;
        inReset = 1'b0;
        @(negedge inClk);
        check("reset_outValid", 512'(outValid), 512'd0);
        check("reset_outBlock", outBlock, 512'd0);
        check("reset_outInReady", 512'(outInReady), 512'd1);
        @(posedge inClk);
        #1;

        // Zero request: inspect the state right after the final-subkey removal.
        send('0, '0, '0, 1'b0, a1);
        @(posedge inClk);
        #1;
        check("load_word7", 512'(dut.block_q[7]), 512'(64'hFFFFFFFFFFFFFFEE));
        for (int i = 0; i < 7; i++) check($sformatf("load_word%0d", i), 512'(dut.block_q[i]), 512'd0);
        check("k8_parity", 512'(dut.k_q[8]), 512'(K_C240));
        pulse_reset();

        // Directed vectors: all-zero and the byte-ramp key/tweak set.
        expect_and_send('0, '0, '0, 1'b0, a1);
        for (int b = 0; b < 64; b++) begin
            key[8*b +: 8] = 8'(8'h10 + b);
            pt[8*b +: 8]  = 8'(8'hFF - b);
        end
        for (int b = 0; b < 16; b++) tw[8*b +: 8] = 8'(b);
        expect_and_send(key, tw, pt, 1'b0, a1);
        drain();

        // Random round trips.
        for (int n = 0; n < 200; n++) begin
            key = rand512();
            pt  = rand512();
            tw  = {$urandom, $urandom, $urandom, $urandom};
            expect_and_send(key, tw, pt, 1'b0, a1);
        end
        drain();

        // Backpressure: result held, new requests ignored.
        inOutReady = 1'b0;
        key   = rand512();
        bp_pt = rand512();
        tw    = {$urandom, $urandom, $urandom, $urandom};
        expect_and_send(key, tw, bp_pt, 1'b0, a1);
        seen = 1'b0;
        for (int w = 0; w < 200 && !seen; w++) begin
            @(negedge inClk);
            seen = outValid;
            @(posedge inClk);
            #1;
        end
        check("bp_valid_timeout", 512'(seen), 512'd1);
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin
                inKey   = rand512();
                inBlock = rand512();
                inValid = 1'b1;
            end
            if (c == 6) inValid = 1'b0;
            @(negedge inClk);
            check("bp_outValid", 512'(outValid), 512'd1);
            check("bp_outBlock", outBlock, bp_pt);
            check("bp_outInReady", 512'(outInReady), 512'd0);
            @(posedge inClk);
            #1;
        end
        inOutReady = 1'b1;
        repeat (5) @(posedge inClk);
        #1;
        @(negedge inClk);
        check("bp_release_ready", 512'(outInReady), 512'd1);
        check("bp_queue_empty", 512'(exp_q.size()), 512'd0);
        @(posedge inClk);
        #1;

        // Reset around round 40 aborts the request.
        send(rand512(), '0, rand512(), 1'b0, a1);
        repeat (33) @(posedge inClk);
        #1;
        pulse_reset();
        @(negedge inClk);
        check("midrst_outValid", 512'(outValid), 512'd0);
        check("midrst_outBlock", outBlock, 512'd0);
        check("midrst_outInReady", 512'(outInReady), 512'd1);
        @(posedge inClk);
        #1;
        key = rand512();
        pt  = rand512();
        tw  = {$urandom, $urandom, $urandom, $urandom};
        expect_and_send(key, tw, pt, 1'b0, a1);
        drain();

        // Back-to-back with inValid held high across both requests.
        expect_and_send(rand512(), {$urandom, $urandom, $urandom, $urandom}, rand512(), 1'b1, a1);
        expect_and_send(rand512(), {$urandom, $urandom, $urandom, $urandom}, rand512(), 1'b0, a2);
        check("b2b_accept_gap", 512'(a2 - last_hs), 512'd1);
        drain();

        repeat (3) @(posedge inClk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
